// File: rtl/stack_pkg.sv
// Shared command encoding for the parameterised stack.
package stack_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

endpackage : stack_pkg

// File: rtl/stack_regfile.sv
// DEPTH x WIDTH cell storage: one synchronous write port, one asynchronous
// read port, synchronous clear of every cell.
module stack_regfile #(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 5,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             srst_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
    always_ff @(posedge clk_i) begin
      if (srst_i) begin
        mem_q[gi] <= '0;
      end else if (we_i && (waddr_i == IDX_W'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  // Addresses past DEPTH-1 exist when DEPTH is not a power of two; read as zero.
  assign rdata_o = (int'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule : stack_regfile

// File: rtl/stack_behaviour_param.sv
// Circular-pointer stack with PUSH/POP/GET and registered flags.
// Define STACK_BEHAVIOUR_WRAP_EN to let PUSH on a full stack overwrite the oldest cell.
module stack_behaviour_param
  import stack_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 5,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [1:0]       COMMAND,
  input  logic [IDX_W-1:0] INDEX,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             OUT_VALID,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY,
  output logic             ERROR
);

  localparam int AW = IDX_W + 2;

  cmd_e             cmd;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             out_valid_q, out_valid_d;
  logic             error_q, error_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;

  logic             we;
  logic [IDX_W-1:0] ptr_inc, ptr_dec, get_addr, rd_addr;
  logic [AW-1:0]    get_off;
  logic [WIDTH-1:0] rd_data;

  assign cmd     = cmd_e'(COMMAND);
  assign ptr_inc = (ptr_q == IDX_W'(DEPTH - 1)) ? '0 : ptr_q + IDX_W'(1);
  assign ptr_dec = (ptr_q == '0) ? IDX_W'(DEPTH - 1) : ptr_q - IDX_W'(1);

  // (ptr-1-INDEX) mod DEPTH; exact whenever INDEX < COUNT, which is the only case used.
  always_comb begin
    get_off = AW'(ptr_q) + AW'(DEPTH - 1) - AW'(INDEX);
    if (get_off >= AW'(DEPTH)) begin
      get_off = get_off - AW'(DEPTH);
    end
    get_addr = IDX_W'(get_off);
  end

  assign rd_addr = (cmd == CMD_POP) ? ptr_dec : get_addr;

  stack_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk_i   (CLK),
    .srst_i  (RESET),
    .we_i    (we),
    .waddr_i (ptr_q),
    .wdata_i (DATA_IN),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    ptr_d       = ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    error_d     = 1'b0;
    we          = 1'b0;
    case (cmd)
      CMD_PUSH: begin
        if (!full_q) begin
          we      = 1'b1;
          ptr_d   = ptr_inc;
          count_d = count_q + CNT_W'(1);
        end else begin
`ifdef STACK_BEHAVIOUR_WRAP_EN
          // With count==DEPTH the pointer sits on the oldest cell.
          we    = 1'b1;
          ptr_d = ptr_inc;
`else
          error_d = 1'b1;
`endif
        end
      end
      CMD_POP: begin
        if (empty_q) begin
          error_d = 1'b1;
        end else begin
          ptr_d       = ptr_dec;
          count_d     = count_q - CNT_W'(1);
          data_out_d  = rd_data;
          out_valid_d = 1'b1;
        end
      end
      CMD_GET: begin
        if (CNT_W'(INDEX) >= count_q) begin
          error_d = 1'b1;
        end else begin
          data_out_d  = rd_data;
          out_valid_d = 1'b1;
        end
      end
      default: ;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q       <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      error_q     <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      error_q     <= error_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  assign DATA_OUT  = data_out_q;
  assign OUT_VALID = out_valid_q;
  assign COUNT     = count_q;
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign ERROR     = error_q;

endmodule : stack_behaviour_param

// File: tb/tb_stack_behaviour_param.sv
// Directed self-checking bench for stack_behaviour_param (WIDTH=4, DEPTH=5).
module tb_stack_behaviour_param;
  import stack_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEPTH = 5;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             CLK = 1'b0;
  logic             RESET;
  logic [1:0]       COMMAND;
  logic [IDX_W-1:0] INDEX;
  logic [WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0] DATA_OUT;
  logic             OUT_VALID;
  logic [CNT_W-1:0] COUNT;
  logic             FULL;
  logic             EMPTY;
  logic             ERROR;

  int checks = 0;
  int errors = 0;

  stack_behaviour_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .COMMAND   (COMMAND),
    .INDEX     (INDEX),
    .DATA_IN   (DATA_IN),
    .DATA_OUT  (DATA_OUT),
    .OUT_VALID (OUT_VALID),
    .COUNT     (COUNT),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .ERROR     (ERROR)
  );

  always #5 CLK = ~CLK;

  // One command per edge; outputs are sampled 1 time unit after the edge.
  task automatic step(input cmd_e c, input int idx, input int din);
    COMMAND = c;
    INDEX   = IDX_W'(idx);
    DATA_IN = WIDTH'(din);
    @(posedge CLK);
    #1;
    COMMAND = CMD_NOP;
    $display("t=%0t rst=%0d cmd=%s idx=%0d din=%0d -> dout=%0d vld=%0d cnt=%0d full=%0d empty=%0d err=%0d",
             $time, RESET, c.name(), idx, din, DATA_OUT, OUT_VALID, COUNT, FULL, EMPTY, ERROR);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step(CMD_NOP, 0, 0);
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    step(CMD_PUSH, 0, 4);
    step(CMD_GET, 0, 0);
    do_reset();
    checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", COUNT); end
    checks++; if (EMPTY !== 1'b1) begin errors++; $display("FAIL reset_empty got %0d exp 1", EMPTY); end
    checks++; if (FULL !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", FULL); end
    checks++; if (DATA_OUT !== 4'd0) begin errors++; $display("FAIL reset_dout got %0d exp 0", DATA_OUT); end
    checks++; if (OUT_VALID !== 1'b0 || ERROR !== 1'b0) begin errors++;
      $display("FAIL reset_pulses got vld=%0d err=%0d exp 0/0", OUT_VALID, ERROR); end
  endtask

  task automatic test_pop_empty();
    do_reset();
    step(CMD_POP, 0, 0);
    checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL pop_empty_err got %0d exp 1", ERROR); end
    checks++; if (OUT_VALID !== 1'b0) begin errors++; $display("FAIL pop_empty_vld got %0d exp 0", OUT_VALID); end
    checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0) begin errors++;
      $display("FAIL pop_empty_state got empty=%0d cnt=%0d exp 1/0", EMPTY, COUNT); end
    step(CMD_NOP, 0, 0);
    checks++; if (ERROR !== 1'b0) begin errors++; $display("FAIL pop_empty_err_pulse got %0d exp 0", ERROR); end
  endtask

  task automatic test_push_pop();
    do_reset();
    step(CMD_PUSH, 0, 3);
    step(CMD_PUSH, 0, 7);
    step(CMD_PUSH, 0, 9);
    checks++; if (COUNT !== 3'd3 || OUT_VALID !== 1'b0) begin errors++;
      $display("FAIL push3_state got cnt=%0d vld=%0d exp 3/0", COUNT, OUT_VALID); end
    step(CMD_POP, 0, 0);
    checks++; if (DATA_OUT !== 4'd9 || OUT_VALID !== 1'b1) begin errors++;
      $display("FAIL pop_first got dout=%0d vld=%0d exp 9/1", DATA_OUT, OUT_VALID); end
    step(CMD_POP, 0, 0);
    checks++; if (DATA_OUT !== 4'd7 || OUT_VALID !== 1'b1) begin errors++;
      $display("FAIL pop_second got dout=%0d vld=%0d exp 7/1", DATA_OUT, OUT_VALID); end
    checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL pop_count got %0d exp 1", COUNT); end
    step(CMD_NOP, 0, 0);
    checks++; if (DATA_OUT !== 4'd7 || OUT_VALID !== 1'b0 || ERROR !== 1'b0) begin errors++;
      $display("FAIL nop_hold got dout=%0d vld=%0d err=%0d exp 7/0/0", DATA_OUT, OUT_VALID, ERROR); end
  endtask

  task automatic test_full_get();
    do_reset();
    for (int v = 1; v <= 5; v++) step(CMD_PUSH, 0, v);
    checks++; if (FULL !== 1'b1 || COUNT !== 3'd5 || EMPTY !== 1'b0) begin errors++;
      $display("FAIL full_flags got full=%0d cnt=%0d empty=%0d exp 1/5/0", FULL, COUNT, EMPTY); end
    step(CMD_GET, 4, 0);
    checks++; if (DATA_OUT !== 4'd1 || OUT_VALID !== 1'b1) begin errors++;
      $display("FAIL get_idx4 got dout=%0d vld=%0d exp 1/1", DATA_OUT, OUT_VALID); end
    step(CMD_GET, 0, 0);
    checks++; if (DATA_OUT !== 4'd5 || OUT_VALID !== 1'b1) begin errors++;
      $display("FAIL get_idx0 got dout=%0d vld=%0d exp 5/1", DATA_OUT, OUT_VALID); end
    checks++; if (COUNT !== 3'd5) begin errors++; $display("FAIL get_count got %0d exp 5", COUNT); end
  endtask

  // Continues from the full 1..5 stack left by test_full_get.
  task automatic test_full_push();
    step(CMD_PUSH, 0, 6);
`ifdef STACK_BEHAVIOUR_WRAP_EN
    checks++; if (ERROR !== 1'b0 || COUNT !== 3'd5 || FULL !== 1'b1) begin errors++;
      $display("FAIL wrap_push got err=%0d cnt=%0d full=%0d exp 0/5/1", ERROR, COUNT, FULL); end
    step(CMD_GET, 0, 0);
    checks++; if (DATA_OUT !== 4'd6) begin errors++; $display("FAIL wrap_get0 got %0d exp 6", DATA_OUT); end
    step(CMD_GET, 4, 0);
    checks++; if (DATA_OUT !== 4'd2) begin errors++; $display("FAIL wrap_get4 got %0d exp 2", DATA_OUT); end
`else
    checks++; if (ERROR !== 1'b1 || COUNT !== 3'd5 || OUT_VALID !== 1'b0) begin errors++;
      $display("FAIL full_push_reject got err=%0d cnt=%0d vld=%0d exp 1/5/0", ERROR, COUNT, OUT_VALID); end
    step(CMD_GET, 0, 0);
    checks++; if (DATA_OUT !== 4'd5 || ERROR !== 1'b0) begin errors++;
      $display("FAIL full_get0 got dout=%0d err=%0d exp 5/0", DATA_OUT, ERROR); end
    step(CMD_GET, 4, 0);
    checks++; if (DATA_OUT !== 4'd1) begin errors++; $display("FAIL full_get4 got %0d exp 1", DATA_OUT); end
`endif
  endtask

  task automatic test_get_range_and_reset();
    do_reset();
    step(CMD_PUSH, 0, 10);
    step(CMD_PUSH, 0, 11);
    step(CMD_GET, 1, 0);
    checks++; if (DATA_OUT !== 4'd10 || OUT_VALID !== 1'b1) begin errors++;
      $display("FAIL get_idx1 got dout=%0d vld=%0d exp 10/1", DATA_OUT, OUT_VALID); end
    step(CMD_GET, 2, 0);
    checks++; if (ERROR !== 1'b1 || OUT_VALID !== 1'b0 || DATA_OUT !== 4'd10 || COUNT !== 3'd2) begin errors++;
      $display("FAIL get_range got err=%0d vld=%0d dout=%0d cnt=%0d exp 1/0/10/2", ERROR, OUT_VALID, DATA_OUT, COUNT); end
    RESET = 1'b1;
    step(CMD_PUSH, 0, 8);
    RESET = 1'b0;
    checks++; if (COUNT !== 3'd0 || EMPTY !== 1'b1 || ERROR !== 1'b0 || DATA_OUT !== 4'd0) begin errors++;
      $display("FAIL reset_push got cnt=%0d empty=%0d err=%0d dout=%0d exp 0/1/0/0", COUNT, EMPTY, ERROR, DATA_OUT); end
    step(CMD_GET, 0, 0);
    checks++; if (ERROR !== 1'b1) begin errors++; $display("FAIL reset_push_discarded got err=%0d exp 1", ERROR); end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    for (int v = 1; v <= 7; v++) begin
      step(CMD_PUSH, 0, v + 8);
      step(CMD_POP, 0, 0);
      checks++; if (DATA_OUT !== WIDTH'(v + 8) || OUT_VALID !== 1'b1) begin errors++;
        $display("FAIL pair_pop%0d got dout=%0d vld=%0d exp %0d/1", v, DATA_OUT, OUT_VALID, v + 8); end
    end
    checks++; if (EMPTY !== 1'b1 || COUNT !== 3'd0) begin errors++;
      $display("FAIL pair_empty got empty=%0d cnt=%0d exp 1/0", EMPTY, COUNT); end
    // Fill to full so the pointer wraps to 0, then drain across the wrap.
    for (int v = 1; v <= 5; v++) step(CMD_PUSH, 0, v + 2);
    for (int v = 5; v >= 1; v--) begin
      step(CMD_POP, 0, 0);
      checks++; if (DATA_OUT !== WIDTH'(v + 2)) begin errors++;
        $display("FAIL drain_pop got %0d exp %0d", DATA_OUT, v + 2); end
    end
    checks++; if (EMPTY !== 1'b1 || FULL !== 1'b0) begin errors++;
      $display("FAIL drain_empty got empty=%0d full=%0d exp 1/0", EMPTY, FULL); end
  endtask

  initial begin
    RESET   = 1'b1;
    COMMAND = CMD_NOP;
    INDEX   = '0;
    DATA_IN = '0;
    step(CMD_NOP, 0, 0);
    RESET = 1'b0;
    test_reset();
    test_pop_empty();
    test_push_pop();
    test_full_get();
    test_full_push();
    test_get_range_and_reset();
    test_pointer_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_stack_behaviour_param
